// File: rtl/ritc_storage_readout.sv
// rtl/ritc_storage_readout.sv - RITC sample ring buffer with triggered freeze and valid/ready readout.
// Optional header word with event count and trigger pointer: define RITC_READOUT_HEADER_EN.
module ritc_storage_readout #(
  parameter int NBITS      = 48,
  parameter int DEPTH_LOG2 = 9,
  parameter int PRETRIG    = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NBITS-1:0]      A_i,
  input  logic [NBITS-1:0]      B_i,
  input  logic [NBITS-1:0]      C_i,
  input  logic                  arm_i,
  input  logic                  trig_i,
  output logic                  busy_o,
  output logic [NBITS-1:0]      dat_o,
  output logic [1:0]            chan_o,
  output logic [DEPTH_LOG2-1:0] addr_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  done_o
);
  localparam int DEPTH   = 2**DEPTH_LOG2;
  localparam int POSTLEN = DEPTH - PRETRIG - 1;
  localparam logic [DEPTH_LOG2-1:0] PRE_V  = DEPTH_LOG2'(PRETRIG);
  localparam logic [DEPTH_LOG2-1:0] POST_V = DEPTH_LOG2'(POSTLEN);
  localparam logic [DEPTH_LOG2-1:0] LAST   = DEPTH_LOG2'(DEPTH - 1);
`ifdef RITC_READOUT_HEADER_EN
  localparam logic [1:0] FIRST_CHAN = 2'd3;
`else
  localparam logic [1:0] FIRST_CHAN = 2'd0;
`endif

  typedef enum logic [2:0] {IDLE, ARMED, POST, READ, DONE} state_t;
  state_t state;

  logic [3*NBITS-1:0]    mem [DEPTH];
  logic [3*NBITS-1:0]    rd_q;
  logic [DEPTH_LOG2-1:0] wp, fill, post_cnt;
  logic [DEPTH_LOG2-1:0] rd_idx, s1_idx, rd_addr;
  logic [1:0]            rd_chan, s1_chan;
  logic                  rd_more, s1_valid;
  logic                  take2, adv1, issue, wr_en;
  logic [NBITS-1:0]      s1_dat;
`ifdef RITC_READOUT_HEADER_EN
  logic [15:0]           evt_cnt;
  logic [DEPTH_LOG2-1:0] wp_trig;
`endif

  // Two-stage read pipe: stage 1 is the registered RAM read, stage 2 the output register.
  assign take2   = !valid_o || ready_i;
  assign adv1    = !s1_valid || take2;
  assign issue   = (state == READ) && adv1 && rd_more;
  assign wr_en   = (state == ARMED) || (state == POST);
  assign rd_addr = wp + rd_idx;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wp] <= {A_i, B_i, C_i};
    if (issue) rd_q <= mem[rd_addr];
  end

  always_comb begin
    case (s1_chan)
      2'd0:    s1_dat = rd_q[3*NBITS-1:2*NBITS];
      2'd1:    s1_dat = rd_q[2*NBITS-1:NBITS];
      2'd2:    s1_dat = rd_q[NBITS-1:0];
`ifdef RITC_READOUT_HEADER_EN
      default: s1_dat = NBITS'({evt_cnt, wp_trig});
`else
      default: s1_dat = rd_q[NBITS-1:0];
`endif
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wp       <= '0;
      fill     <= '0;
      post_cnt <= '0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      done_o   <= 1'b0;
      dat_o    <= '0;
      chan_o   <= '0;
      addr_o   <= '0;
      s1_valid <= 1'b0;
      s1_chan  <= '0;
      s1_idx   <= '0;
      rd_chan  <= '0;
      rd_idx   <= '0;
      rd_more  <= 1'b0;
`ifdef RITC_READOUT_HEADER_EN
      evt_cnt  <= '0;
      wp_trig  <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (arm_i) begin
            state  <= ARMED;
            fill   <= '0;
            busy_o <= 1'b1;
          end
        end
        ARMED: begin
          wp <= wp + 1'b1;
          if (fill != PRE_V) begin
            fill <= fill + 1'b1;
          end else if (trig_i) begin
`ifdef RITC_READOUT_HEADER_EN
            evt_cnt <= evt_cnt + 1'b1;
            wp_trig <= wp;
`endif
            post_cnt <= POST_V;
            rd_chan  <= FIRST_CHAN;
            rd_idx   <= '0;
            rd_more  <= 1'b1;
            state    <= (POSTLEN == 0) ? READ : POST;
          end
        end
        POST: begin
          wp       <= wp + 1'b1;
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == DEPTH_LOG2'(1)) state <= READ;
        end
        READ: begin
          if (adv1) begin
            s1_valid <= rd_more;
            if (rd_more) begin
              s1_chan <= rd_chan;
              s1_idx  <= rd_idx;
              if (rd_chan == 2'd3) begin
                rd_chan <= 2'd0;
                rd_idx  <= '0;
              end else if (rd_idx == LAST) begin
                if (rd_chan == 2'd2) rd_more <= 1'b0;
                else rd_chan <= rd_chan + 1'b1;
                rd_idx <= '0;
              end else begin
                rd_idx <= rd_idx + 1'b1;
              end
            end
          end
          if (take2) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
              dat_o  <= s1_dat;
              chan_o <= s1_chan;
              addr_o <= s1_idx;
            end
          end
          // Acceptance of the final C word ends the event.
          if (valid_o && ready_i && chan_o == 2'd2 && addr_o == LAST) begin
            state   <= DONE;
            valid_o <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ritc_storage_readout.sv
// tb/tb_ritc_storage_readout.sv - randomized self-checking bench for ritc_storage_readout.
module tb_ritc_storage_readout;
  localparam int NBITS = 48;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
`ifdef RITC_READOUT_HEADER_EN
  localparam int HOFF = 1;
`else
  localparam int HOFF = 0;
`endif
  localparam int NW = 3*DEPTH + HOFF;

  logic clk = 1'b0;
  logic rst = 1'b1, arm = 1'b0, trig = 1'b0, ready = 1'b0;
  logic [NBITS-1:0] a_s, b_s, c_s, dat;
  logic [1:0] chan;
  logic [DL-1:0] addr;
  logic busy, valid, done;
  int unsigned cyc = 0;

  int checks = 0, fails = 0;
  int wr_total = 0, evt_model = 0, ca = 0, tt = 0;
  logic [NBITS-1:0] exp_dat[$], got_dat[$];
  logic [1:0] exp_chan[$], got_chan[$];
  logic [DL-1:0] exp_addr[$], got_addr[$];
  int done_cnt, stall_err, first_valid, last_valid, valid_cycles;
  bit timed_out, busy_after;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign a_s = NBITS'(cyc);
  assign b_s = a_s + 48'h100;
  assign c_s = a_s + 48'h200;

  ritc_storage_readout #(.NBITS(NBITS), .DEPTH_LOG2(DL), .PRETRIG(PRE)) dut (
    .clk_i(clk), .rst_i(rst), .A_i(a_s), .B_i(b_s), .C_i(c_s),
    .arm_i(arm), .trig_i(trig), .busy_o(busy), .dat_o(dat), .chan_o(chan),
    .addr_o(addr), .valid_o(valid), .ready_i(ready), .done_o(done)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1; arm = 0; trig = 0; ready = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    wr_total = 0;
    evt_model = 0;
  endtask

  task automatic pulse_arm();
    arm = 1; ca = int'(cyc);
    @(negedge clk);
    arm = 0;
  endtask

  task automatic pulse_trig();
    trig = 1; tt = int'(cyc);
    @(negedge clk);
    trig = 0;
  endtask

  // Window = samples from PRETRIG cycles before the accepted trigger, oldest first, channel-major.
  task automatic build_expected();
    int wpt;
    wpt = (wr_total + tt - ca - 1) % DEPTH;
    evt_model++;
    wr_total += tt - ca + DEPTH - PRE - 1;
    exp_dat.delete(); exp_chan.delete(); exp_addr.delete();
`ifdef RITC_READOUT_HEADER_EN
    exp_dat.push_back(NBITS'({16'(evt_model), DL'(wpt)}));
    exp_chan.push_back(2'd3);
    exp_addr.push_back('0);
`endif
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < DEPTH; i++) begin
        exp_dat.push_back(NBITS'(tt - PRE + i + ch*256));
        exp_chan.push_back(2'(ch));
        exp_addr.push_back(DL'(i));
      end
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random; noise pulses arm/trig randomly
  task automatic capture(input int mode, input bit noise);
    bit prev_stall;
    logic [NBITS-1:0] pd;
    logic [1:0] pc;
    logic [DL-1:0] pa;
    got_dat.delete(); got_chan.delete(); got_addr.delete();
    done_cnt = 0; stall_err = 0; first_valid = -1; last_valid = -1; valid_cycles = 0;
    timed_out = 1; busy_after = 1; prev_stall = 0; pd = '0; pc = '0; pa = '0;
    for (int n = 0; n < 600; n++) begin
      if (prev_stall && (valid !== 1'b1 || dat !== pd || chan !== pc || addr !== pa)) stall_err++;
      if (done === 1'b1) begin
        done_cnt++; arm = 0; trig = 0; ready = 0;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        busy_after = busy;
        timed_out = 0;
        break;
      end
      case (mode)
        0: ready = 1;
        1: ready = (n % 4 == 0) || (n % 4 == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (valid === 1'b1) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = int'(cyc);
        last_valid = int'(cyc);
        if (ready) begin
          got_dat.push_back(dat); got_chan.push_back(chan); got_addr.push_back(addr);
        end
      end
      prev_stall = (valid === 1'b1) && !ready;
      pd = dat; pc = chan; pa = addr;
      if (noise) begin
        arm = 1'($urandom_range(0, 1));
        trig = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    arm = 0; trig = 0; ready = 0;
  endtask

  task automatic test_reset();
    bit seen;
    do_reset();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (dat !== '0) begin fails++; $display("FAIL reset_dat: got %h want 0", dat); end
    checks++; if (chan !== 2'd0) begin fails++; $display("FAIL reset_chan: got %0d want 0", chan); end
    checks++; if (addr !== '0) begin fails++; $display("FAIL reset_addr: got %0d want 0", addr); end
    pulse_trig();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_trig_busy: got %b want 0", busy); end
    arm = 1; trig = 1;
    @(negedge clk);
    arm = 0; trig = 0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL arm_busy: got %b want 1", busy); end
    seen = 0;
    repeat (3*DEPTH) begin
      if (valid === 1'b1) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL arm_trig_same_cycle: valid_seen %b busy %b want 0 1", seen, busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    pulse_arm();
    repeat (9) @(negedge clk);
    pulse_trig();
    build_expected();
    capture(0, 0);
    checks++; if (timed_out) begin fails++; $display("FAIL basic_timeout: got timeout want done"); end
    checks++; if (got_dat.size() != NW) begin fails++; $display("FAIL basic_count: got %0d want %0d", got_dat.size(), NW); end
    for (int i = 0; i < got_dat.size() && i < NW; i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i] || got_chan[i] !== exp_chan[i] || got_addr[i] !== exp_addr[i]) begin
        fails++; $display("FAIL basic_word[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i,
          got_dat[i], got_chan[i], got_addr[i], exp_dat[i], exp_chan[i], exp_addr[i]);
      end
    end
    checks++; if (valid_cycles != NW || last_valid - first_valid + 1 != NW) begin
      fails++; $display("FAIL basic_throughput: got %0d valid over %0d cycles want %0d", valid_cycles, last_valid - first_valid + 1, NW);
    end
    checks++; if (first_valid > tt + DEPTH - PRE + 2) begin
      fails++; $display("FAIL basic_latency: got first valid cycle %0d want <= %0d", first_valid, tt + DEPTH - PRE + 2);
    end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_pulse: got %0d want 1", done_cnt); end
    checks++; if (busy_after !== 1'b0) begin fails++; $display("FAIL basic_idle_after: got busy %b want 0", busy_after); end
  endtask

  task automatic test_early_trig();
    do_reset();
    pulse_arm();
    @(negedge clk);
    pulse_trig();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL early_trig_armed: got busy %b want 1", busy); end
    repeat (4) @(negedge clk);
    pulse_trig();
    build_expected();
    capture(2, 0);
    checks++; if (timed_out || got_dat.size() != NW) begin
      fails++; $display("FAIL early_count: got %0d timeout %b want %0d", got_dat.size(), timed_out, NW);
    end
    for (int i = 0; i < got_dat.size() && i < NW; i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i] || got_chan[i] !== exp_chan[i] || got_addr[i] !== exp_addr[i]) begin
        fails++; $display("FAIL early_word[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i,
          got_dat[i], got_chan[i], got_addr[i], exp_dat[i], exp_chan[i], exp_addr[i]);
      end
    end
    if (got_dat.size() > HOFF + PRE) begin
      checks++;
      if (got_dat[HOFF + PRE] !== NBITS'(tt)) begin
        fails++; $display("FAIL early_trig_index: got %h want %h", got_dat[HOFF + PRE], NBITS'(tt));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    pulse_arm();
    repeat ($urandom_range(4, 11)) @(negedge clk);
    pulse_trig();
    build_expected();
    capture(1, 0);
    checks++; if (timed_out || got_dat.size() != NW) begin
      fails++; $display("FAIL stall_count: got %0d timeout %b want %0d", got_dat.size(), timed_out, NW);
    end
    checks++; if (stall_err != 0) begin fails++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_err); end
    for (int i = 0; i < got_dat.size() && i < NW; i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i] || got_chan[i] !== exp_chan[i] || got_addr[i] !== exp_addr[i]) begin
        fails++; $display("FAIL stall_word[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i,
          got_dat[i], got_chan[i], got_addr[i], exp_dat[i], exp_chan[i], exp_addr[i]);
      end
    end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL stall_done_pulse: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_read();
    int nacc;
    bit reached;
    do_reset();
    pulse_arm();
    repeat (6) @(negedge clk);
    pulse_trig();
    nacc = 0; reached = 0; ready = 1;
    for (int n = 0; n < 200; n++) begin
      if (valid === 1'b1) nacc++;
      @(negedge clk);
      if (nacc >= 20) begin reached = 1; break; end
    end
    checks++; if (!reached) begin fails++; $display("FAIL midrst_reach: got %0d words want 20", nacc); end
    rst = 1;
    @(negedge clk);
    rst = 0; ready = 0; wr_total = 0; evt_model = 0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_idle: got valid %b busy %b want 0 0", valid, busy);
    end
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL midrst_quiet: got valid %b want 0", valid); end
    pulse_arm();
    repeat (7) @(negedge clk);
    pulse_trig();
    build_expected();
    capture(0, 0);
    checks++; if (timed_out || got_dat.size() != NW) begin
      fails++; $display("FAIL midrst_count: got %0d timeout %b want %0d", got_dat.size(), timed_out, NW);
    end
    for (int i = 0; i < got_dat.size() && i < NW; i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i] || got_chan[i] !== exp_chan[i] || got_addr[i] !== exp_addr[i]) begin
        fails++; $display("FAIL midrst_word[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i,
          got_dat[i], got_chan[i], got_addr[i], exp_dat[i], exp_chan[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_ignore_inputs();
    do_reset();
    pulse_arm();
    repeat ($urandom_range(4, 11)) @(negedge clk);
    pulse_trig();
    build_expected();
    capture(2, 1);
    checks++; if (timed_out || got_dat.size() != NW) begin
      fails++; $display("FAIL ignore_count: got %0d timeout %b want %0d", got_dat.size(), timed_out, NW);
    end
    for (int i = 0; i < got_dat.size() && i < NW; i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i] || got_chan[i] !== exp_chan[i] || got_addr[i] !== exp_addr[i]) begin
        fails++; $display("FAIL ignore_word[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i,
          got_dat[i], got_chan[i], got_addr[i], exp_dat[i], exp_chan[i], exp_addr[i]);
      end
    end
    checks++; if (done_cnt != 1 || busy_after !== 1'b0) begin
      fails++; $display("FAIL ignore_done: got pulses %0d busy %b want 1 0", done_cnt, busy_after);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int ev = 0; ev < 3; ev++) begin
      pulse_arm();
      repeat ($urandom_range(0, 9)) @(negedge clk);
      pulse_trig();
      while (tt - ca < PRE + 1) begin
        checks++; if (busy !== 1'b1 || valid !== 1'b0) begin
          fails++; $display("FAIL b2b_drop[%0d]: got busy %b valid %b want 1 0", ev, busy, valid);
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        pulse_trig();
      end
      build_expected();
      capture(2, 0);
      checks++; if (timed_out || got_dat.size() != NW) begin
        fails++; $display("FAIL b2b_count[%0d]: got %0d timeout %b want %0d", ev, got_dat.size(), timed_out, NW);
      end
      for (int i = 0; i < got_dat.size() && i < NW; i++) begin
        checks++;
        if (got_dat[i] !== exp_dat[i] || got_chan[i] !== exp_chan[i] || got_addr[i] !== exp_addr[i]) begin
          fails++; $display("FAIL b2b_word[%0d][%0d]: got %h/%0d/%0d want %h/%0d/%0d", ev, i,
            got_dat[i], got_chan[i], got_addr[i], exp_dat[i], exp_chan[i], exp_addr[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_trig();
    test_stall();
    test_reset_mid_read();
    test_ignore_inputs();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end
endmodule
